// File: rtl/bram_word_streamer_if.sv
// rtl/bram_word_streamer_if.sv - RAM read port and byte stream bundle for the word streamer
//
// Purpose: groups the two buses the streamer sits between.
//   RAM read side : r_en, r_addr (streamer -> RAM), rd_data, rd_valid (RAM -> streamer)
//   Byte stream   : tx_data, tx_valid (streamer -> UART), tx_ready (UART -> streamer)
// Modports:
//   master - the streamer (issues reads, sources bytes)
//   slave  - the RAM / transmitter side
interface bram_word_streamer_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic              r_en;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport master (
    output r_en, r_addr, tx_data, tx_valid,
    input  rd_data, rd_valid, tx_ready
  );

  modport slave (
    input  r_en, r_addr, tx_data, tx_valid,
    output rd_data, rd_valid, tx_ready
  );
endinterface

// File: rtl/bram_word_streamer.sv
// rtl/bram_word_streamer.sv - dumps a run of RAM words as a high-byte-first byte stream
//
// Purpose: on an accepted start, reads length words beginning at base_addr
// (address wraps modulo 2**ADDR_W), splits each word into two bytes, high
// byte first, and offers them on a valid/ready stream. A running mod-256
// checksum of the bytes sent is kept until the next accepted start.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   start      - dump request, honoured only in IDLE and not during done
//   base_addr  - first word address, latched on accepted start
//   length     - word count 0..2**ADDR_W, latched on accepted start
//   bus        - master side of the RAM read port and byte stream
//   busy       - high while a dump is reading or sending
//   done       - one-cycle pulse after a dump completes
//   checksum   - mod-256 sum of bytes sent in the current or last dump
module bram_word_streamer #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  bram_word_streamer_if.master bus,
  output logic              busy,
  output logic              done,
  output logic [7:0]        checksum
);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT,
    SEND_HI,
    SEND_LO,
    FINISH
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   remaining;
  // The high byte goes straight into tx_data when the word arrives, so only
  // the low byte needs to be held until SEND_LO.
  logic [7:0]        word_lo;
  logic              handshake;

  assign handshake = bus.tx_valid && bus.tx_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      addr       <= '0;
      remaining  <= '0;
      word_lo    <= '0;
      bus.r_en   <= 1'b0;
      bus.r_addr <= '0;
      bus.tx_data  <= '0;
      bus.tx_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      checksum   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // done is still high in the first IDLE cycle after FINISH; a start
          // landing on that cycle belongs to the finished dump and is dropped.
          if (start && !done) begin
            addr      <= base_addr;
            remaining <= length;
            checksum  <= '0;
            if (length == '0) begin
              state <= FINISH;
            end else begin
              state      <= READ;
              bus.r_en   <= 1'b1;
              bus.r_addr <= base_addr;
              busy       <= 1'b1;
            end
          end
        end

        READ: begin
          bus.r_en <= 1'b0;
          state    <= WAIT;
        end

        WAIT: begin
          if (bus.rd_valid) begin
            word_lo      <= bus.rd_data[7:0];
            bus.tx_data  <= bus.rd_data[DATA_W-1 -: 8];
            bus.tx_valid <= 1'b1;
            state        <= SEND_HI;
          end
        end

        SEND_HI: begin
          if (handshake) begin
            checksum    <= checksum + bus.tx_data;
            bus.tx_data <= word_lo;
            state       <= SEND_LO;
          end
        end

        SEND_LO: begin
          if (handshake) begin
            checksum     <= checksum + bus.tx_data;
            bus.tx_valid <= 1'b0;
            addr         <= addr + 1'b1;
            remaining    <= remaining - 1'b1;
            if (remaining == {{ADDR_W{1'b0}}, 1'b1}) begin
              state <= FINISH;
              busy  <= 1'b0;
            end else begin
              state      <= READ;
              bus.r_en   <= 1'b1;
              bus.r_addr <= addr + 1'b1;
            end
          end
        end

        FINISH: begin
          done  <= 1'b1;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
